// File: rtl/cvxif_multi_coprocessor.sv
// CV-X-IF style coprocessor: ADD2/ADD3 with an in-order outstanding-instruction queue.
// Optional build macro CVXIF_COPRO_EXC_EN: funct3 111 is accepted and returns an exception.
module cvxif_multi_coprocessor #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NUM_RS   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_instr_i,
    input  logic [ID_WIDTH-1:0]      issue_id_i,
    input  logic [NUM_RS*XLEN-1:0]   issue_rs_i,
    input  logic [NUM_RS-1:0]        issue_rs_valid_i,
    output logic                     issue_accept_o,
    output logic                     issue_writeback_o,
    input  logic                     commit_valid_i,
    input  logic                     commit_kill_i,
    input  logic [ID_WIDTH-1:0]      commit_id_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [ID_WIDTH-1:0]      result_id_o,
    output logic [XLEN-1:0]          result_data_o,
    output logic [4:0]               result_rd_o,
    output logic                     result_we_o,
    output logic                     result_exc_o,
    output logic [5:0]               result_exccode_o,
    output logic                     busy_o
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RS_W   = 3 * XLEN;
    localparam logic [6:0]  OPCODE = 7'b0001011;

    typedef enum logic [2:0] {E_FREE, E_ISSUED, E_EXEC, E_DONE, E_KILLED} entry_state_e;

    entry_state_e          state_q [DEPTH];
    logic [ID_WIDTH-1:0]   id_q    [DEPTH];
    logic [4:0]            rd_q    [DEPTH];
    logic [XLEN-1:0]       data_q  [DEPTH];
    logic [1:0]            cnt_q   [DEPTH];
    logic                  exc_q   [DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;

    logic [RS_W-1:0]  rs_ext;
    logic [2:0]       rsv_ext;
    logic [XLEN-1:0]  rs1, rs2, rs3, sum;
    logic [2:0]       funct3;
    logic             opc_ok, is_add2, is_add3, is_exc, legal, ops_ok, full, issue_fire;
    logic             commit_hit;
    logic [PTR_W-1:0] commit_idx;
    logic             head_done, head_killed, head_free;
    logic             unused_instr;

    assign unused_instr = ^issue_instr_i[31:15];

    // Decode, operand availability and issue handshake
    always_comb begin
        rs_ext  = RS_W'(issue_rs_i);
        rsv_ext = 3'(issue_rs_valid_i);
        rs1     = rs_ext[0 +: XLEN];
        rs2     = rs_ext[XLEN +: XLEN];
        rs3     = rs_ext[2*XLEN +: XLEN];
        funct3  = issue_instr_i[14:12];
        opc_ok  = (issue_instr_i[6:0] == OPCODE);
        is_add2 = opc_ok && (funct3 == 3'b000);
        is_add3 = opc_ok && (funct3 == 3'b001) && (NUM_RS == 3);
`ifdef CVXIF_COPRO_EXC_EN
        is_exc  = opc_ok && (funct3 == 3'b111);
`else
        is_exc  = 1'b0;
`endif
        legal   = is_add2 || is_add3 || is_exc;
        ops_ok  = is_add3 ? (&rsv_ext) : (is_add2 ? (&rsv_ext[1:0]) : 1'b1);
        sum     = is_add3 ? (rs1 + rs2 + rs3) : (is_add2 ? (rs1 + rs2) : '0);
        // Entries retire in order, so the tail slot is busy only when every slot is.
        full              = (state_q[tail_q] != E_FREE);
        issue_ready_o     = !full && ops_ok;
        issue_accept_o    = issue_valid_i && legal;
        issue_writeback_o = issue_valid_i && (is_add2 || is_add3);
        issue_fire        = issue_valid_i && issue_ready_o && legal;
    end

    // Find the first ISSUED entry whose id matches the commit
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!commit_hit && commit_valid_i && (state_q[i] == E_ISSUED) &&
                (id_q[i] == commit_id_i)) begin
                commit_hit = 1'b1;
                commit_idx = PTR_W'(i);
            end
        end
    end

    // Head entry drives the result port; everything else reads zero
    always_comb begin
        head_done        = (state_q[head_q] == E_DONE);
        head_killed      = (state_q[head_q] == E_KILLED);
        head_free        = (head_done && result_ready_i) || head_killed;
        result_valid_o   = head_done;
        result_id_o      = head_done ? id_q[head_q]   : '0;
        result_data_o    = head_done ? data_q[head_q] : '0;
        result_rd_o      = head_done ? rd_q[head_q]   : '0;
        result_we_o      = head_done && !exc_q[head_q];
        result_exc_o     = head_done && exc_q[head_q];
        result_exccode_o = (head_done && exc_q[head_q]) ? 6'd2 : 6'd0;
    end

    // Any entry outstanding
    always_comb begin
        busy_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (state_q[i] != E_FREE) busy_o = 1'b1;
        end
    end

    // Entry state machine, latency counters and queue pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[i] <= E_FREE;
                id_q[i]    <= '0;
                rd_q[i]    <= '0;
                data_q[i]  <= '0;
                cnt_q[i]   <= '0;
                exc_q[i]   <= 1'b0;
            end
            head_q <= '0;
            tail_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (state_q[i] == E_EXEC) begin
                    if (cnt_q[i] == 2'd0) state_q[i] <= E_DONE;
                    else                  cnt_q[i]   <= cnt_q[i] - 2'd1;
                end
            end
            // Latency L=sum[1:0]: DONE L+1 cycles after commit; L=0 goes straight to DONE.
            if (commit_hit) begin
                if (commit_kill_i) begin
                    state_q[commit_idx] <= E_KILLED;
                end else if (data_q[commit_idx][1:0] == 2'd0) begin
                    state_q[commit_idx] <= E_DONE;
                end else begin
                    state_q[commit_idx] <= E_EXEC;
                    cnt_q[commit_idx]   <= data_q[commit_idx][1:0] - 2'd1;
                end
            end
            if (head_free) begin
                state_q[head_q] <= E_FREE;
                head_q          <= head_q + PTR_W'(1);
            end
            if (issue_fire) begin
                state_q[tail_q] <= E_ISSUED;
                id_q[tail_q]    <= issue_id_i;
                rd_q[tail_q]    <= issue_instr_i[11:7];
                data_q[tail_q]  <= sum;
                cnt_q[tail_q]   <= '0;
                exc_q[tail_q]   <= is_exc;
                tail_q          <= tail_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: doc/cvxif_multi_coprocessor.md
CVXIF_MULTI_COPROCESSOR -- requirements
Module: cvxif_multi_coprocessor

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter ID_WIDTH, default 4, instruction ID width.
REQ-003 SHALL have parameter DEPTH, default 4, outstanding-instruction entries (power of two, 2..16).
REQ-004 SHALL have parameter NUM_RS, default 2, source operands (2 or 3).
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 issue_valid_i  in  1  issue request valid.
REQ-008 issue_ready_o  out  1  issue request can be taken.
REQ-009 issue_instr_i  in  32  offloaded instruction.
REQ-010 issue_id_i  in  ID_WIDTH  instruction ID.
REQ-011 issue_rs_i  in  NUM_RS*XLEN  operands, rs1 in LSBs.
REQ-012 issue_rs_valid_i  in  NUM_RS  per-operand valid.
REQ-013 issue_accept_o, issue_writeback_o  out  1 each  issue response.
REQ-014 commit_valid_i, commit_kill_i  in  1 each; commit_id_i  in  ID_WIDTH.
REQ-015 result_valid_o  out  1; result_ready_i  in  1.
REQ-016 result_id_o  out  ID_WIDTH; result_data_o  out  XLEN; result_rd_o  out  5; result_we_o  out  1.
REQ-017 result_exc_o  out  1; result_exccode_o  out  6.
REQ-018 busy_o  out  1  any entry not FREE.

Function
REQ-019 Decode: opcode 7'b0001011, funct3 000 = ADD2 (rs1+rs2); funct3 001 = ADD3 (rs1+rs2+rs3), legal only if NUM_RS==3; anything else rejected.
REQ-020 issue_accept_o and issue_writeback_o SHALL be combinational, equal 1 only for legal decode while issue_valid_i=1; 0 otherwise.
REQ-021 issue_ready_o = not full AND all operands needed by the decoded op valid; for a rejected instruction, ready = not full.
REQ-022 Handshake on issue_valid_i & issue_ready_o; accepted op allocated at tail, stores id, rd=instr[11:7], sum (mod 2^XLEN); rejected op allocates nothing.
REQ-023 Entry states: FREE -> ISSUED (accept) -> EXEC (commit, kill=0) -> DONE (counter expired) -> FREE (result handshake); ISSUED -> KILLED (commit, kill=1) -> FREE.
REQ-024 Commit SHALL match the ISSUED entry with equal id; no match is ignored; one commit per cycle.
REQ-025 EXEC latency L = sum[1:0]; entry becomes DONE L+1 cycles after the commit cycle.
REQ-026 Results in allocation order: only the head entry drives result_*; result_valid_o = head is DONE.
REQ-027 result_* SHALL hold stable while result_valid_o=1 and result_ready_i=0.
REQ-028 Head in KILLED SHALL be freed in one cycle with result_valid_o=0.
REQ-029 result_we_o = result_valid_o; result_exc_o=0, result_exccode_o=0 unless REQ-036 applies.
REQ-030 Full (DEPTH entries non-FREE): issue_ready_o=0; allocation in the same cycle as head free SHALL NOT occur (ready from registered full).
REQ-031 Pointers SHALL wrap modulo DEPTH.
REQ-032 Commit and issue in the same cycle with different ids SHALL both take effect; commit on the id being issued that cycle is ignored.

Reset
REQ-033 On rst_ni=0 all entries FREE, head=tail=0, counters 0, asynchronously.
REQ-034 Reset values: issue_ready_o=1 (when inputs permit), result_valid_o=0, busy_o=0, all result_* = 0.
REQ-035 Reset mid-operation SHALL discard every outstanding entry; no result emitted afterwards.

Configuration
REQ-036 With CVXIF_COPRO_EXC_EN defined, funct3 111 SHALL be accepted (writeback=0), follow normal commit/latency (L=0) and return result_exc_o=1, result_exccode_o=2, result_we_o=0; without it funct3 111 is rejected.

Verification
REQ-037 ADD2 rs1=5, rs2=7, commit id 1 kill 0, ready=1 -> result data 12, id 1, valid 1 cycle after commit+... exactly L+1=1 cycle (L=0).
REQ-038 Four ADD2 issued (DEPTH=4), no commit -> issue_ready_o=0; one commit+result drain -> issue_ready_o=1 next cycle.
REQ-039 ids 2,3 issued, kill id 2, commit id 3 -> only id 3 result, id 2 never appears.
REQ-040 result_ready_i=0 for 5 cycles on valid result data 0x10 -> outputs held, one handshake on release.
REQ-041 rst_ni pulsed with 3 entries outstanding -> busy_o=0, result_valid_o=0, no later result.
REQ-042 Instr funct3 111 -> accept=0 (macro off); accept=1, exc=1, exccode=2 (macro on).
